// File: rtl/bip_pkg.sv
// Shared definitions for the BIP I run/step controller.
//   HALT_OP, CMD_*  : default opcode/command constants
//   REPORT_LEN      : number of bytes in a status report
//   run_state_t     : controller state encoding (also exported on DBG_STATE)
package bip_pkg;

    localparam logic [4:0] HALT_OP  = 5'b00000;
    localparam logic [7:0] CMD_RUN  = 8'h72;  // 'r'
    localparam logic [7:0] CMD_STEP = 8'h73;  // 's'
    localparam logic [7:0] CMD_CLR  = 8'h63;  // 'c'

    localparam int REPORT_LEN = 6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_STEP = 3'd2,
        ST_CLR  = 3'd3,
        ST_SEND = 3'd4
    } run_state_t;

endpackage

// File: rtl/bip_report_tx.sv
// Status report serializer.
// Captures a 48-bit snapshot on LOAD and streams it MSB byte first over a
// valid/ready link, then pulses DONE in the cycle the last byte transfers.
//   CLK, RESET         : clock, synchronous active-high reset
//   LOAD, SNAPSHOT     : capture strobe and {PC16, ACC, CNT} snapshot
//   TX_DATA, TX_VALID  : byte offered to the UART transmitter
//   TX_READY           : transmitter accepts the offered byte
//   DONE               : combinational, high on the final byte's transfer cycle
//
// Handshake: a byte transfers on a rising edge where TX_VALID and TX_READY
// are both high. TX_VALID never drops and TX_DATA never changes before that
// edge; the following byte is offered in the very next cycle.
module bip_report_tx
    import bip_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        LOAD,
    input  logic [47:0] SNAPSHOT,
    output logic [7:0]  TX_DATA,
    output logic        TX_VALID,
    input  logic        TX_READY,
    output logic        DONE
);

    localparam logic [2:0] LAST_IDX = 3'(REPORT_LEN - 1);

    logic [47:0] snap_q;
    logic [2:0]  idx_q;
    logic        active_q;
    logic        last_byte;

    assign last_byte = (idx_q == LAST_IDX);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            snap_q   <= '0;
            idx_q    <= '0;
            active_q <= 1'b0;
        end else if (LOAD) begin
            snap_q   <= SNAPSHOT;
            idx_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q && TX_READY) begin
            if (last_byte) begin
                active_q <= 1'b0;
                idx_q    <= '0;
            end else begin
                idx_q <= idx_q + 3'd1;
            end
        end
    end

    // Outside a report the data lines idle at zero rather than echoing
    // the previous report's first byte.
    always_comb begin
        TX_DATA = 8'h00;
        if (active_q) begin
            case (idx_q)
                3'd0:    TX_DATA = snap_q[47:40];
                3'd1:    TX_DATA = snap_q[39:32];
                3'd2:    TX_DATA = snap_q[31:24];
                3'd3:    TX_DATA = snap_q[23:16];
                3'd4:    TX_DATA = snap_q[15:8];
                3'd5:    TX_DATA = snap_q[7:0];
                default: TX_DATA = 8'h00;
            endcase
        end
    end

    assign TX_VALID = active_q;
    assign DONE     = active_q && TX_READY && last_byte;

endmodule

// File: rtl/bip_run_controller.sv
// Run/step sequencer for the BIP I core.
// Decodes host command bytes, gates the CPU clock enable, stops on HALT or
// on cycle-counter saturation, and streams a 6-byte status report
// {0,PC[10:8]}, PC[7:0], ACC[15:8], ACC[7:0], CNT[15:8], CNT[7:0].
//   CLK, RESET          : clock, synchronous active-high reset
//   RX_DATA, RX_VALID   : command byte strobe from the UART receiver
//   INSTRUCTION, PC, ACC: live CPU state
//   CPU_EN              : CPU clock enable (combinational)
//   CPU_RESET           : registered one-cycle CPU/data-memory reset
//   TX_DATA/VALID/READY : report byte stream to the UART transmitter
//   BUSY                : high whenever not IDLE
//   DBG_STATE           : current controller state
module bip_run_controller
    import bip_pkg::*;
#(
    parameter logic [4:0] HALT_OP  = bip_pkg::HALT_OP,
    parameter logic [7:0] CMD_RUN  = bip_pkg::CMD_RUN,
    parameter logic [7:0] CMD_STEP = bip_pkg::CMD_STEP,
    parameter logic [7:0] CMD_CLR  = bip_pkg::CMD_CLR
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    input  logic [15:0] INSTRUCTION,
    input  logic [10:0] PC,
    input  logic [15:0] ACC,
    output logic        CPU_EN,
    output logic        CPU_RESET,
    output logic [7:0]  TX_DATA,
    output logic        TX_VALID,
    input  logic        TX_READY,
    output logic        BUSY,
    output logic [2:0]  DBG_STATE
);

    run_state_t  state, next_state;
    logic [15:0] cnt_q;
    logic        cpu_reset_q;
    logic        step_snap_q;
    logic        snap_load;
    logic        tx_done;
    logic        is_halt;
    logic        cnt_sat;

    assign is_halt = (INSTRUCTION[15:11] == HALT_OP);
    assign cnt_sat = (cnt_q == 16'hFFFF);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= ST_IDLE;
            cpu_reset_q <= 1'b0;
            step_snap_q <= 1'b0;
        end else begin
            state       <= next_state;
            cpu_reset_q <= (next_state == ST_CLR);
            // A step's effect on PC/ACC is only visible one cycle later,
            // so its snapshot is deferred to the first SEND cycle.
            step_snap_q <= (state == ST_STEP);
        end
    end

    always_comb begin
        next_state = state;
        CPU_EN     = 1'b0;
        snap_load  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (RX_VALID) begin
                    if (RX_DATA == CMD_RUN)       next_state = ST_RUN;
                    else if (RX_DATA == CMD_STEP) next_state = ST_STEP;
                    else if (RX_DATA == CMD_CLR)  next_state = ST_CLR;
                end
            end
            ST_RUN: begin
                // HALT never receives an enable; a saturated counter acts
                // as a watchdog and stops the run the same way.
                if (is_halt || cnt_sat) begin
                    snap_load  = 1'b1;
                    next_state = ST_SEND;
                end else begin
                    CPU_EN = 1'b1;
                end
            end
            ST_STEP: begin
                CPU_EN     = !is_halt;
                next_state = ST_SEND;
            end
            ST_CLR: begin
                next_state = ST_IDLE;
            end
            ST_SEND: begin
                snap_load = step_snap_q;
                if (tx_done) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET || state == ST_CLR) begin
            cnt_q <= '0;
        end else if (CPU_EN && !cnt_sat) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    bip_report_tx u_report_tx (
        .CLK      (CLK),
        .RESET    (RESET),
        .LOAD     (snap_load),
        .SNAPSHOT ({5'b00000, PC, ACC, cnt_q}),
        .TX_DATA  (TX_DATA),
        .TX_VALID (TX_VALID),
        .TX_READY (TX_READY),
        .DONE     (tx_done)
    );

    assign CPU_RESET = cpu_reset_q;
    assign BUSY      = (state != ST_IDLE);
    assign DBG_STATE = state;

endmodule

// File: tb/tb_bip_run_controller.sv
// Bench for bip_run_controller: a tiny behavioural CPU supplies
// INSTRUCTION/PC/ACC, while a program-level reference model predicts
// enable-cycle counts and report bytes.
module tb_bip_run_controller;
    import bip_pkg::*;

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUBI = 5'b00111;
    localparam logic [4:0] OP_JMP  = 5'b01000;

    // ---------------- clock / reset / signals ----------------
    logic        CLK = 1'b0;
    logic        RESET;
    logic [7:0]  RX_DATA;
    logic        RX_VALID;
    logic [15:0] INSTRUCTION;
    logic [10:0] PC;
    logic [15:0] ACC;
    logic        CPU_EN;
    logic        CPU_RESET;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_READY;
    logic        BUSY;
    logic [2:0]  DBG_STATE;

    always #5 CLK = ~CLK;

    bip_run_controller dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .RX_DATA     (RX_DATA),
        .RX_VALID    (RX_VALID),
        .INSTRUCTION (INSTRUCTION),
        .PC          (PC),
        .ACC         (ACC),
        .CPU_EN      (CPU_EN),
        .CPU_RESET   (CPU_RESET),
        .TX_DATA     (TX_DATA),
        .TX_VALID    (TX_VALID),
        .TX_READY    (TX_READY),
        .BUSY        (BUSY),
        .DBG_STATE   (DBG_STATE)
    );

    // ---------------- instruction semantics ----------------
    function automatic logic [10:0] f_next_pc(input logic [10:0] pc, input logic [15:0] ins);
        if (ins[15:11] == OP_JMP) return ins[10:0];
        return pc + 11'd1;
    endfunction

    function automatic logic [15:0] f_next_acc(input logic [15:0] acc, input logic [15:0] ins);
        logic [15:0] imm;
        imm = {5'b00000, ins[10:0]};
        case (ins[15:11])
            OP_LDI:  return imm;
            OP_ADDI: return acc + imm;
            OP_SUBI: return acc - imm;
            default: return acc;
        endcase
    endfunction

    // ---------------- behavioural CPU ----------------
    logic [15:0] prog [0:15];
    logic [10:0] cpu_pc;
    logic [15:0] cpu_acc;

    assign INSTRUCTION = prog[cpu_pc[3:0]];
    assign PC  = cpu_pc;
    assign ACC = cpu_acc;

    always @(posedge CLK) begin
        if (RESET || CPU_RESET) begin
            cpu_pc  <= '0;
            cpu_acc <= '0;
        end else if (CPU_EN) begin
            cpu_pc  <= f_next_pc(cpu_pc, INSTRUCTION);
            cpu_acc <= f_next_acc(cpu_acc, INSTRUCTION);
        end
    end

    // ---------------- reference model + scoreboard ----------------
    logic [10:0] m_pc;
    logic [15:0] m_acc;
    logic [15:0] m_cnt;
    int          m_en;
    logic [7:0]  exp_q[$];
    int          tests = 0;
    int          fails = 0;

    task automatic model_clear();
        m_pc = '0; m_acc = '0; m_cnt = '0;
    endtask

    // A run executes instructions until HALT is next or 65535 cycles are counted.
    task automatic model_run();
        m_en = 0;
        while (prog[m_pc[3:0]][15:11] != HALT_OP && m_cnt != 16'hFFFF) begin
            m_acc = f_next_acc(m_acc, prog[m_pc[3:0]]);
            m_pc  = f_next_pc(m_pc, prog[m_pc[3:0]]);
            m_cnt = m_cnt + 16'd1;
            m_en  = m_en + 1;
        end
    endtask

    task automatic model_step();
        m_en = 0;
        if (prog[m_pc[3:0]][15:11] != HALT_OP) begin
            m_acc = f_next_acc(m_acc, prog[m_pc[3:0]]);
            m_pc  = f_next_pc(m_pc, prog[m_pc[3:0]]);
            m_en  = 1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
    endtask

    task automatic push_report();
        exp_q.push_back({5'b00000, m_pc[10:8]});
        exp_q.push_back(m_pc[7:0]);
        exp_q.push_back(m_acc[15:8]);
        exp_q.push_back(m_acc[7:0]);
        exp_q.push_back(m_cnt[15:8]);
        exp_q.push_back(m_cnt[7:0]);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic send_cmd(input logic [7:0] b);
        RX_DATA  = b;
        RX_VALID = 1'b1;
        tick();
        RX_VALID = 1'b0;
        RX_DATA  = 8'h00;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = {OP_HLT, 11'd0};
    endtask

    task automatic do_clr();
        send_cmd(CMD_CLR);
        check("clr_cpu_reset", 32'(CPU_RESET), 1);
        check("clr_busy", 32'(BUSY), 1);
        check("clr_tx_valid", 32'(TX_VALID), 0);
        tick();
        check("clr_cpu_reset_end", 32'(CPU_RESET), 0);
        check("clr_idle", 32'(BUSY), 0);
        check("clr_no_tx", 32'(TX_VALID), 0);
        model_clear();
    endtask

    // Sits in RUN until the first report byte is offered; optionally fires a
    // CLR command mid-run, which must be ignored.
    task automatic run_to_send(input bit inject_clr, output int en_seen);
        int cyc = 0;
        int crst = 0;
        int halt_en = 0;
        en_seen = 0;
        TX_READY = 1'b0;
        while (!TX_VALID && cyc < 70000) begin
            if (CPU_EN) en_seen++;
            if (CPU_RESET) crst++;
            if (CPU_EN && INSTRUCTION[15:11] == HALT_OP) halt_en++;
            if (inject_clr && cyc == 1) begin
                RX_DATA = CMD_CLR; RX_VALID = 1'b1;
            end else begin
                RX_VALID = 1'b0;
            end
            tick();
            cyc++;
        end
        RX_VALID = 1'b0;
        check("run_timeout", 32'(cyc < 70000), 1);
        check("run_no_cpu_reset", crst, 0);
        check("run_halt_no_en", halt_en, 0);
        check("run_send_cpu_en", 32'(CPU_EN), 0);
    endtask

    task automatic collect(input int stall_idx, input int stall_len, input bit rnd, output int cyc);
        int idx = 0;
        int st = 0;
        bit rdy;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 500) begin
            if (idx == stall_idx && st < stall_len) begin
                rdy = 1'b0;
                st++;
                check("stall_valid", 32'(TX_VALID), 1);
                check("stall_data", 32'(TX_DATA), 32'(exp_q[0]));
            end else begin
                rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            TX_READY = rdy;
            if (TX_VALID && rdy) begin
                check("tx_byte", 32'(TX_DATA), 32'(exp_q.pop_front()));
                idx++;
            end
            tick();
            cyc++;
        end
        TX_READY = 1'b0;
        check("report_complete", exp_q.size(), 0);
        check("after_report_busy", 32'(BUSY), 0);
        check("after_report_valid", 32'(TX_VALID), 0);
        exp_q.delete();
    endtask

    task automatic do_step();
        int c;
        model_step();
        send_cmd(CMD_STEP);
        check("step_cpu_en", 32'(CPU_EN), m_en);
        check("step_busy", 32'(BUSY), 1);
        push_report();
        collect(-1, 0, 1'b0, c);
        check("step_send_len", c, 8);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int en;
        int c;
        int len;
        logic [4:0] op;

        RESET = 1'b1; RX_DATA = 8'h00; RX_VALID = 1'b0; TX_READY = 1'b0;
        clear_prog();
        tick(); tick();
        check("rst_cpu_en", 32'(CPU_EN), 0);
        check("rst_cpu_reset", 32'(CPU_RESET), 0);
        check("rst_tx_valid", 32'(TX_VALID), 0);
        check("rst_tx_data", 32'(TX_DATA), 0);
        check("rst_busy", 32'(BUSY), 0);
        check("rst_state", 32'(DBG_STATE), 0);
        RESET = 1'b0;
        model_clear();
        tick();

        // Single steps: LDI 7, STO, HLT. Third step lands on HALT (no enable).
        prog[0] = {OP_LDI, 11'd7};
        prog[1] = {OP_STO, 11'd0};
        do_step();
        do_step();
        check("step2_pc", 32'(m_pc), 2);
        do_step();

        // Run LDI 5, ADDI 3, STO, HLT with a 10-cycle stall on byte index 1.
        clear_prog();
        prog[0] = {OP_LDI, 11'd5};
        prog[1] = {OP_ADDI, 11'd3};
        prog[2] = {OP_STO, 11'd0};
        do_clr();
        send_cmd(CMD_RUN);
        check("run_busy", 32'(BUSY), 1);
        model_run();
        run_to_send(1'b1, en);
        check("run_en_cycles", en, m_en);
        check("run_en_three", en, 3);
        push_report();
        check("run_exp_acc", 32'(m_acc), 8);
        collect(1, 10, 1'b0, c);
        check("run_send_len", c, 16);

        // Clear after the report, then a step proves the counter restarted.
        do_clr();
        do_step();

        // Unknown command byte leaves the controller idle.
        send_cmd(8'h41);
        check("unk_busy", 32'(BUSY), 0);
        check("unk_state", 32'(DBG_STATE), 0);
        check("unk_cpu_en", 32'(CPU_EN), 0);
        tick();
        check("unk_tx_valid", 32'(TX_VALID), 0);

        // Random straight-line programs: a few steps, then run to HALT.
        for (int r = 0; r < 5; r++) begin
            clear_prog();
            len = $urandom_range(2, 10);
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 3))
                    0:       op = OP_LDI;
                    1:       op = OP_ADDI;
                    2:       op = OP_SUBI;
                    default: op = OP_STO;
                endcase
                prog[i] = {op, 11'($urandom_range(0, 2047))};
            end
            do_clr();
            for (int s = 0; s < int'($urandom_range(0, 2)); s++) do_step();
            send_cmd(CMD_RUN);
            model_run();
            run_to_send(1'b0, en);
            check("rnd_en_cycles", en, m_en);
            push_report();
            collect(-1, 0, 1'b1, c);
        end

        // Reset while the third report byte is offered.
        clear_prog();
        prog[0] = {OP_LDI, 11'd5};
        prog[1] = {OP_ADDI, 11'd3};
        prog[2] = {OP_STO, 11'd0};
        do_clr();
        send_cmd(CMD_RUN);
        run_to_send(1'b0, en);
        TX_READY = 1'b1;
        tick();
        tick();
        TX_READY = 1'b0;
        check("mid_byte2_valid", 32'(TX_VALID), 1);
        check("mid_byte2_data", 32'(TX_DATA), 0);
        RESET = 1'b1;
        tick();
        check("mid_rst_tx_valid", 32'(TX_VALID), 0);
        check("mid_rst_busy", 32'(BUSY), 0);
        check("mid_rst_cpu_en", 32'(CPU_EN), 0);
        RESET = 1'b0;
        model_clear();
        tick();
        check("mid_rst_stays_idle", 32'(BUSY), 0);

        // Jump-to-self: the counter saturates and acts as a watchdog.
        clear_prog();
        prog[0] = {OP_JMP, 11'd0};
        do_clr();
        send_cmd(CMD_RUN);
        model_run();
        run_to_send(1'b0, en);
        check("sat_en_cycles", en, 65535);
        check("sat_model_cnt", 32'(m_cnt), 32'hFFFF);
        push_report();
        collect(-1, 0, 1'b1, c);
        check("sat_idle_state", 32'(DBG_STATE), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
